// File: rtl/cfg_bridge_pkg.sv
// cfg_bridge_pkg
// Shared definitions for the configuration bus bridge: the FSM state
// encoding, the default timeout and a helper that sizes the timeout counter.
package cfg_bridge_pkg;

  // Bridge FSM states; IDLE must stay at encoding 0 so reset lands there.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bridge_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  // Bits needed to hold values 0..max_val, i.e. ceil(log2(max_val+1)).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cfg_bridge_timer.sv
// cfg_bridge_timer
// Saturating transaction timeout counter.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset
//   clr          : restart the count from 0 (transaction accepted)
//   en           : count this cycle (bridge is in ISSUE or WAIT)
//   hit          : the count reaches TIMEOUT at the end of this cycle
module cfg_bridge_timer
  import cfg_bridge_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count enabled cycles, stopping at TIMEOUT so the value never wraps.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CW'(TIMEOUT))) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Flagged on the enabled cycle whose increment brings the count to TIMEOUT,
  // so a transaction gets exactly TIMEOUT cycles in ISSUE/WAIT.
  assign hit = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/cfg_bus_bridge.sv
// cfg_bus_bridge
// Bridges single-cycle system bus requests onto a clock-crossing handshake
// toward the register domain, with a timeout and stale-ack recovery.
// Ports:
//   clk_i, rst_i                : clock and synchronous active-high reset
//   sys_addr_i/wdata_i          : request address / write data
//   sys_wen_i/sys_ren_i         : single-cycle write / read request
//   sys_rdata_o/err_o/ack_o     : single-cycle completion with data / error
//   ctrl_addr_o/ctrl_wdata_o    : held address / data toward the handshake
//   ctrl_we_o/ctrl_re_o         : single-cycle triggers to the handshake
//   ctrl_ack_i/ctrl_rdata_i     : handshake completion and read data
//   busy_o                      : bridge is not idle
module cfg_bus_bridge
  import cfg_bridge_pkg::*;
#(
  parameter int AW      = 20,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] sys_addr_i,
  input  logic [DW-1:0] sys_wdata_i,
  input  logic          sys_wen_i,
  input  logic          sys_ren_i,
  output logic [DW-1:0] sys_rdata_o,
  output logic          sys_err_o,
  output logic          sys_ack_o,
  output logic [AW-1:0] ctrl_addr_o,
  output logic [DW-1:0] ctrl_wdata_o,
  output logic          ctrl_we_o,
  output logic          ctrl_re_o,
  input  logic          ctrl_ack_i,
  input  logic [DW-1:0] ctrl_rdata_i,
  output logic          busy_o
);

  bridge_state_t state_q;
  logic          is_write_q;
  logic          stale_q;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_hit;
  logic          accept;

  assign accept    = (state_q == ST_IDLE) && (sys_wen_i || sys_ren_i);
  assign timer_clr = accept;
  assign timer_en  = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign busy_o    = (state_q != ST_IDLE);

  cfg_bridge_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (timer_clr),
    .en   (timer_en),
    .hit  (timer_hit)
  );

  // Bridge FSM. Triggers are registered: they are raised on the edge that
  // makes ISSUE active with stale_q clear, so a trigger is high exactly in
  // the single ISSUE cycle that hands the request to the handshake.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      is_write_q   <= 1'b0;
      stale_q      <= 1'b0;
      ctrl_addr_o  <= '0;
      ctrl_wdata_o <= '0;
      ctrl_we_o    <= 1'b0;
      ctrl_re_o    <= 1'b0;
      sys_ack_o    <= 1'b0;
      sys_err_o    <= 1'b0;
      sys_rdata_o  <= '0;
    end else begin
      ctrl_we_o   <= 1'b0;
      ctrl_re_o   <= 1'b0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;

      // An ack owed to a timed-out transaction only frees the handshake.
      if (stale_q && ctrl_ack_i) begin
        stale_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            ctrl_addr_o  <= sys_addr_i;
            ctrl_wdata_o <= sys_wdata_i;
            is_write_q   <= sys_wen_i;
            if (!stale_q || ctrl_ack_i) begin
              ctrl_we_o <= sys_wen_i;
              ctrl_re_o <= !sys_wen_i;
            end
            state_q <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (timer_hit) begin
            // If the trigger went out this cycle the handshake is now busy
            // with an answer nobody will wait for.
            if (!stale_q) begin
              stale_q <= 1'b1;
            end
            sys_ack_o <= 1'b1;
            sys_err_o <= 1'b1;
            state_q   <= ST_RESP;
          end else if (!stale_q) begin
            state_q <= ST_WAIT;
          end else if (ctrl_ack_i) begin
            ctrl_we_o <= is_write_q;
            ctrl_re_o <= !is_write_q;
          end
        end

        ST_WAIT: begin
          // Ack beats a timeout landing in the same cycle.
          if (ctrl_ack_i) begin
            sys_ack_o   <= 1'b1;
            sys_rdata_o <= is_write_q ? '0 : ctrl_rdata_i;
            state_q     <= ST_RESP;
          end else if (timer_hit) begin
            stale_q   <= 1'b1;
            sys_ack_o <= 1'b1;
            sys_err_o <= 1'b1;
            state_q   <= ST_RESP;
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cfg_bus_bridge.md
CFG_BUS_BRIDGE -- requirements
Module: cfg_bus_bridge

Interface
REQ-001 SHALL have parameter AW, default 20, system/ctrl address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles from ISSUE entry to ctrl ack (range 2..65535).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  sole clock, ctrl-side domain.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 sys_addr_i  in  AW  bus address, valid with wen/ren.
REQ-008 sys_wdata_i  in  DW  bus write data, valid with wen.
REQ-009 sys_wen_i  in  1  single-cycle write request.
REQ-010 sys_ren_i  in  1  single-cycle read request.
REQ-011 sys_rdata_o  out  DW  read data, valid with sys_ack_o.
REQ-012 sys_err_o  out  1  error flag, valid with sys_ack_o.
REQ-013 sys_ack_o  out  1  single-cycle completion.
REQ-014 ctrl_addr_o  out  AW  address to register domain, held stable.
REQ-015 ctrl_wdata_o  out  DW  write data to register domain, held stable.
REQ-016 ctrl_we_o  out  1  single-cycle write trigger to the clock-crossing handshake.
REQ-017 ctrl_re_o  out  1  single-cycle read trigger to the clock-crossing handshake.
REQ-018 ctrl_ack_i  in  1  single-cycle completion pulse from the handshake.
REQ-019 ctrl_rdata_i  in  DW  register-domain read data, quasi-static, valid when ctrl_ack_i is high.
REQ-020 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE: on sys_wen_i or sys_ren_i, SHALL latch addr, wdata and kind, then go to ISSUE. Write wins if both are high; the request is then a write only.
REQ-023 Requests arriving outside IDLE SHALL be ignored, with no side effect.
REQ-024 ctrl_addr_o and ctrl_wdata_o SHALL update only on acceptance in IDLE, and SHALL hold until the next acceptance.
REQ-025 ISSUE with stale_q=0: SHALL pulse ctrl_we_o (write) or ctrl_re_o (read) for exactly one cycle, then go to WAIT.
REQ-026 ISSUE with stale_q=1: SHALL hold without pulsing until stale_q clears. The downstream handshake drops triggers while it is busy.
REQ-027 A timeout counter SHALL clear on ISSUE entry and increment each cycle in ISSUE/WAIT. When it reaches TIMEOUT, the FSM SHALL go to RESP with error set.
REQ-028 WAIT: on ctrl_ack_i, SHALL go to RESP. For reads, it SHALL capture ctrl_rdata_i in that cycle.
REQ-029 If ack and timeout occur in the same cycle, ack SHALL win (no error).
REQ-030 RESP: SHALL assert sys_ack_o for one cycle, with sys_err_o equal to the error flag, then go to IDLE.
REQ-031 sys_rdata_o SHALL be the captured data for a successful read, and 0 for writes and errors. sys_err_o and sys_rdata_o SHALL be 0 whenever sys_ack_o=0.
REQ-032 Timeout while in WAIT SHALL set stale_q. Timeout while in ISSUE with stale_q=1 SHALL leave stale_q unchanged.
REQ-033 While stale_q=1, any ctrl_ack_i SHALL clear stale_q and SHALL otherwise be discarded: no capture, no RESP.
REQ-034 A ctrl_ack_i in IDLE, ISSUE or RESP with stale_q=0 SHALL be ignored.
REQ-035 Latency with no stall: request at cycle 0, trigger at cycle 1, ack at cycle k (k>=2), sys_ack_o at cycle k+1.
REQ-036 The counter SHALL saturate and never wrap. Its width SHALL be ceil(log2(TIMEOUT+1)).

Reset
REQ-037 rst_i SHALL return the FSM to IDLE from any state, dropping any in-flight transaction with no sys_ack_o.
REQ-038 rst_i SHALL clear all outputs, stale_q, the counter and the latches to 0.
REQ-039 The first request after reset release SHALL be accepted in the same cycle that rst_i is low.

Structure
REQ-040 State encodings and the default TIMEOUT SHALL live in shared package cfg_bridge_pkg.
REQ-041 The timeout counter SHALL be sub-module cfg_bridge_timer, with ports clr, en, hit.
REQ-042 The clock-crossing handshake SHALL be instantiated by the parent, not inside this block.

Verification
REQ-043 Write: wen, addr=0x00010, wdata=0xDEADBEEF, ack at cycle 5 -> ctrl_we_o=1 at cycle 1 only, ctrl_wdata_o=0xDEADBEEF, sys_ack_o at cycle 6, err=0, rdata=0.
REQ-044 Read: ren, addr=0x00020, ack at cycle 4 with ctrl_rdata_i=0x12345678 -> ctrl_re_o at cycle 1, sys_ack_o at cycle 5, rdata=0x12345678.
REQ-045 Timeout: TIMEOUT=8, no ack -> sys_ack_o plus sys_err_o at cycle 9, and stale_q=1. Then a new read is held in ISSUE until a late ack clears stale_q; that ack is not reported. The next cycle pulses ctrl_re_o.
REQ-046 Collision: wen and ren in the same cycle -> write only. A second wen during WAIT -> ignored, and exactly one sys_ack_o results.
REQ-047 Reset mid-WAIT: rst_i for one cycle at cycle 3 -> no sys_ack_o, all outputs 0, and a following ren is accepted normally.
REQ-048 Boundary: ack in the same cycle as the counter hits TIMEOUT -> err=0, data captured, stale_q stays 0.
